// File: rtl/tetris_pkg.sv
// Shared types for the Tetris core: FSM states and command encodings used by
// the piece position controller.
package tetris_pkg;

    localparam int ROT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        LOCKED
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_DROP,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_ROT
    } cmd_t;

endpackage

// File: rtl/grav_timer.sv
// Gravity timer: free-running divider that emits a one-cycle tick every
// GRAV_DIV enabled clock cycles. Disabling it freezes the count.
module grav_timer #(
    parameter int GRAV_DIV = 50000000,
    parameter int GRAV_CW  = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [GRAV_CW-1:0] LAST = GRAV_CW'(GRAV_DIV - 1);

    logic [GRAV_CW-1:0] cnt;

    // Tick is asserted in the cycle whose edge wraps the counter back to 0.
    assign tick = en && (cnt == LAST);

    // Count enabled cycles, wrapping at GRAV_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piece_pos_ctrl.sv
// Falling-piece position controller. Arbitrates spawn, gravity and user moves,
// rejects out-of-field moves locally, confirms legal candidates with the
// external collision checker, and pulses landed when the piece locks.
module piece_pos_ctrl
    import tetris_pkg::*;
#(
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int FIELD_W  = 10,
    parameter int FIELD_H  = 20,
    parameter int SPAWN_X  = 5,
    parameter int SPAWN_Y  = 0,
    parameter int GRAV_DIV = 50000000,
    parameter int GRAV_CW  = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spawn,
    input  logic           drop,
    input  logic           left,
    input  logic           right,
    input  logic           rotate,
    input  logic           grav_en,
    input  logic           chk_done,
    input  logic           chk_hit,
    output logic           chk_valid,
    output logic [X_W-1:0] cand_x,
    output logic [Y_W-1:0] cand_y,
    output logic [1:0]     cand_rot,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     pos_rot,
    output logic           busy,
    output logic           landed
);

    localparam logic [X_W-1:0] X_SPAWN = X_W'(SPAWN_X);
    localparam logic [Y_W-1:0] Y_SPAWN = Y_W'(SPAWN_Y);
    localparam logic [X_W-1:0] X_LAST  = X_W'(FIELD_W - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(FIELD_H - 1);

    state_t           state, state_n;
    cmd_t             cmd_q, cmd_n;
    logic             grav_pend, grav_pend_n;
    logic             landed_n;
    logic             tick;
    logic [X_W-1:0]   pos_x_n, cand_x_n;
    logic [Y_W-1:0]   pos_y_n, cand_y_n;
    logic [ROT_W-1:0] pos_rot_n, cand_rot_n;

    grav_timer #(
        .GRAV_DIV (GRAV_DIV),
        .GRAV_CW  (GRAV_CW)
    ) u_grav_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (grav_en),
        .tick  (tick)
    );

    // The checker sees a candidate exactly while the FSM waits in CHECK, so an
    // async reset of the state drops chk_valid immediately.
    assign chk_valid = (state == CHECK);
    assign busy      = (state != IDLE);

    // Next-state, command arbitration and position/candidate updates.
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves it unassigned, which would infer a latch.
        state_n     = state;
        cmd_n       = cmd_q;
        grav_pend_n = grav_pend | tick;
        landed_n    = 1'b0;
        pos_x_n     = pos_x;
        pos_y_n     = pos_y;
        pos_rot_n   = pos_rot;
        cand_x_n    = cand_x;
        cand_y_n    = cand_y;
        cand_rot_n  = cand_rot;

        case (state)
            IDLE: begin
                // Candidate starts as the committed position; one field changes.
                cand_x_n   = pos_x;
                cand_y_n   = pos_y;
                cand_rot_n = pos_rot;
                if (spawn) begin
                    pos_x_n   = X_SPAWN;
                    pos_y_n   = Y_SPAWN;
                    pos_rot_n = '0;
                end else if (drop || grav_pend || tick) begin
                    grav_pend_n = 1'b0;
                    if (pos_y == Y_LAST) begin
                        // Bottom row: no check needed, the piece locks here.
                        state_n  = LOCKED;
                        landed_n = 1'b1;
                    end else begin
                        cand_y_n = pos_y + 1'b1;
                        cmd_n    = CMD_DROP;
                        state_n  = CHECK;
                    end
                end else if (left) begin
                    if (pos_x != '0) begin
                        cand_x_n = pos_x - 1'b1;
                        cmd_n    = CMD_LEFT;
                        state_n  = CHECK;
                    end
                end else if (right) begin
                    if (pos_x != X_LAST) begin
                        cand_x_n = pos_x + 1'b1;
                        cmd_n    = CMD_RIGHT;
                        state_n  = CHECK;
                    end
                end else if (rotate) begin
                    cand_rot_n = pos_rot + 1'b1;
                    cmd_n      = CMD_ROT;
                    state_n    = CHECK;
                end
            end

            CHECK: begin
                if (spawn) begin
                    // Spawn aborts the outstanding check.
                    pos_x_n   = X_SPAWN;
                    pos_y_n   = Y_SPAWN;
                    pos_rot_n = '0;
                    state_n   = IDLE;
                end else if (chk_done) begin
                    if (!chk_hit) begin
                        pos_x_n   = cand_x;
                        pos_y_n   = cand_y;
                        pos_rot_n = cand_rot;
                        state_n   = IDLE;
                    end else if (cmd_q == CMD_DROP) begin
                        state_n  = LOCKED;
                        landed_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            LOCKED: begin
                grav_pend_n = 1'b0;
                if (spawn) begin
                    pos_x_n   = X_SPAWN;
                    pos_y_n   = Y_SPAWN;
                    pos_rot_n = '0;
                    state_n   = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Outside CHECK the candidate simply mirrors the committed position.
        if (state_n != CHECK) begin
            cand_x_n   = pos_x_n;
            cand_y_n   = pos_y_n;
            cand_rot_n = pos_rot_n;
            cmd_n      = CMD_NONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Position, candidate, pending-gravity and landed registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= CMD_NONE;
            grav_pend <= 1'b0;
            landed    <= 1'b0;
            pos_x     <= X_SPAWN;
            pos_y     <= Y_SPAWN;
            pos_rot   <= '0;
            cand_x    <= X_SPAWN;
            cand_y    <= Y_SPAWN;
            cand_rot  <= '0;
        end else begin
            cmd_q     <= cmd_n;
            grav_pend <= grav_pend_n;
            landed    <= landed_n;
            pos_x     <= pos_x_n;
            pos_y     <= pos_y_n;
            pos_rot   <= pos_rot_n;
            cand_x    <= cand_x_n;
            cand_y    <= cand_y_n;
            cand_rot  <= cand_rot_n;
        end
    end

endmodule

// File: tb/tb_piece_pos_ctrl.sv
// Directed bench for piece_pos_ctrl: a table of single-cycle vectors plus
// hand-written sequences for edge-of-field, gravity, landing and reset cases.
module tb_piece_pos_ctrl;

    localparam int CMD_L = 0;
    localparam int CMD_R = 1;
    localparam int CMD_D = 2;
    localparam int CMD_T = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spawn, drop, left, right, rotate, grav_en, chk_done, chk_hit;
    logic       chk_valid, busy, landed;
    logic [4:0] cand_x, cand_y, pos_x, pos_y;
    logic [1:0] cand_rot, pos_rot;

    int n_vec = 0;
    int n_err = 0;

    piece_pos_ctrl #(
        .X_W(5), .Y_W(5), .FIELD_W(10), .FIELD_H(20),
        .SPAWN_X(5), .SPAWN_Y(0), .GRAV_DIV(4), .GRAV_CW(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spawn(spawn), .drop(drop), .left(left),
        .right(right), .rotate(rotate), .grav_en(grav_en),
        .chk_done(chk_done), .chk_hit(chk_hit), .chk_valid(chk_valid),
        .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot),
        .pos_x(pos_x), .pos_y(pos_y), .pos_rot(pos_rot),
        .busy(busy), .landed(landed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic spawn, drop, left, right, rot, done, hit;
        int   px, py, pr, cx, cy, cr, cv, busy, land;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        spawn = 0; drop = 0; left = 0; right = 0; rotate = 0;
        chk_done = 0; chk_hit = 0;
    endtask

    task automatic set_cmd(input int which, input logic v);
        case (which)
            CMD_L:   left   = v;
            CMD_R:   right  = v;
            CMD_D:   drop   = v;
            default: rotate = v;
        endcase
    endtask

    // Issue one legal command, expect a candidate, answer it one cycle later.
    task automatic do_move(input int which, input logic hit);
        set_cmd(which, 1'b1);
        step();
        set_cmd(which, 1'b0);
        check("move_chk_valid", chk_valid, 1);
        chk_done = 1; chk_hit = hit;
        step();
        chk_done = 0; chk_hit = 0;
    endtask

    task automatic check_pos(input string name, input int x, input int y, input int r);
        check({name, "_x"}, pos_x, x);
        check({name, "_y"}, pos_y, y);
        check({name, "_rot"}, pos_rot, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_x;
        int land_cnt;
        int last_y;
        int bad_step;

        //               sp dr lf rt ro dn ht  px py pr cx cy cr cv bs ld
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 5, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 0,  5, 0, 0, 4, 0, 0, 1, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 4, 0, 0, 1, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 1, 0,  4, 0, 0, 4, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 0,  4, 0, 0, 5, 0, 0, 1, 1, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 1, 1,  4, 0, 0, 4, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 0,  4, 0, 0, 4, 0, 1, 1, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 0,  4, 0, 1, 4, 0, 1, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 0,  4, 0, 1, 4, 1, 1, 1, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 0,  4, 1, 1, 4, 1, 1, 0, 0, 0};
        vecs[10] = '{1, 0, 1, 0, 0, 0, 0,  5, 0, 0, 5, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 1, 1, 1, 0, 0,  5, 0, 0, 4, 0, 0, 1, 1, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 0, 0,  5, 0, 0, 5, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 1, 0,  5, 0, 0, 5, 0, 0, 0, 0, 0};

        clear_in();
        grav_en = 0;
        rst_n = 0;
        #22;
        rst_n = 1;

        // Reset state after 10 idle cycles.
        repeat (10) step();
        check_pos("rst_pos", 5, 0, 0);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_landed", landed, 0);

        // Table of single-cycle vectors.
        for (int i = 0; i < 14; i++) begin
            spawn = vecs[i].spawn; drop = vecs[i].drop; left = vecs[i].left;
            right = vecs[i].right; rotate = vecs[i].rot;
            chk_done = vecs[i].done; chk_hit = vecs[i].hit;
            step();
            check($sformatf("v%0d_pos_x", i), pos_x, vecs[i].px);
            check($sformatf("v%0d_pos_y", i), pos_y, vecs[i].py);
            check($sformatf("v%0d_pos_rot", i), pos_rot, vecs[i].pr);
            check($sformatf("v%0d_cand_x", i), cand_x, vecs[i].cx);
            check($sformatf("v%0d_cand_y", i), cand_y, vecs[i].cy);
            check($sformatf("v%0d_cand_rot", i), cand_rot, vecs[i].cr);
            check($sformatf("v%0d_chk_valid", i), chk_valid, vecs[i].cv);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_landed", i), landed, vecs[i].land);
        end
        clear_in();

        // Eleven left presses from x=5: five legal, six rejected at x=0.
        exp_x = 5;
        for (int i = 0; i < 11; i++) begin
            if (exp_x > 0) begin
                do_move(CMD_L, 1'b0);
                exp_x = exp_x - 1;
            end else begin
                left = 1;
                step();
                left = 0;
                check("left_edge_no_check", chk_valid, 0);
                check("left_edge_busy", busy, 0);
            end
            check("left_seq_x", pos_x, exp_x);
        end

        // Nine rights to x=9, then a rejected right at the right wall.
        for (int i = 0; i < 9; i++) do_move(CMD_R, 1'b0);
        check("right_reach_x", pos_x, 9);
        right = 1;
        step();
        right = 0;
        check("right_edge_no_check", chk_valid, 0);
        check("right_edge_x", pos_x, 9);

        // Rotation wraps 3 -> 0.
        for (int i = 1; i <= 4; i++) begin
            do_move(CMD_T, 1'b0);
            check("rot_wrap", pos_rot, i % 4);
        end

        // Drop to y=7, then a drop that collides locks the piece.
        for (int i = 0; i < 7; i++) do_move(CMD_D, 1'b0);
        check("drop_reach_y", pos_y, 7);
        drop = 1;
        step();
        drop = 0;
        check("hit_drop_valid", chk_valid, 1);
        check("hit_drop_cand_y", cand_y, 8);
        chk_done = 1; chk_hit = 1;
        step();
        chk_done = 0; chk_hit = 0;
        check("hit_drop_y", pos_y, 7);
        check("hit_drop_landed", landed, 1);
        check("hit_drop_busy", busy, 1);
        step();
        check("hit_drop_landed_once", landed, 0);
        left = 1;
        step();
        left = 0;
        check("locked_left_ignored", pos_x, 9);
        check("locked_left_no_check", chk_valid, 0);
        spawn = 1;
        step();
        spawn = 0;
        check_pos("spawn_after_lock", 5, 0, 0);
        check("spawn_after_lock_busy", busy, 0);

        // Gravity with an always-clear checker until the piece lands at y=19.
        grav_en  = 1;
        land_cnt = 0;
        last_y   = 0;
        bad_step = 0;
        for (int c = 0; c < 200; c++) begin
            chk_done = chk_valid;
            step();
            if (landed === 1'b1) land_cnt++;
            if (int'(pos_y) != last_y) begin
                if (int'(pos_y) != last_y + 1) bad_step++;
                last_y = int'(pos_y);
            end
            if (chk_valid === 1'b1 && cand_y > 5'd19) bad_step++;
        end
        chk_done = 0;
        grav_en  = 0;
        check("grav_final_y", pos_y, 19);
        check("grav_landed_count", land_cnt, 1);
        check("grav_bad_steps", bad_step, 0);
        check("grav_locked_busy", busy, 1);
        check("grav_locked_no_check", chk_valid, 0);
        left = 1;
        step();
        left = 0;
        check("grav_locked_left", pos_x, 5);
        drop = 1;
        step();
        drop = 0;
        check("grav_locked_drop_y", pos_y, 19);
        check("grav_locked_drop_valid", chk_valid, 0);
        check("grav_locked_drop_landed", landed, 0);
        spawn = 1;
        step();
        spawn = 0;
        check_pos("grav_respawn", 5, 0, 0);

        // Asynchronous reset while a candidate is outstanding.
        do_move(CMD_L, 1'b0);
        check("async_pre_x", pos_x, 4);
        left = 1;
        step();
        left = 0;
        check("async_mid_check_valid", chk_valid, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_chk_valid", chk_valid, 0);
        check("async_busy", busy, 0);
        check_pos("async_pos", 5, 0, 0);
        #2;
        rst_n = 1;
        step();
        check_pos("async_after_release", 5, 0, 0);
        check("async_after_valid", chk_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
